// File: rtl/game_sequencer.sv
// game_sequencer: round-flow controller for the Pac-Man datapath.
// Runs the round phases (idle, ready countdown, play, death, level clear,
// game over). Owns the score, lives and level registers. Gates motion and
// issues one-cycle reload/reposition pulses.
//
// Ports:
//   clk, rst      - system clock, async active-high reset
//   frame_tick    - one-cycle pulse per movement step; phase-timer enable
//   start         - start button (level); rising edge detected here
//   pellet_eaten  - one-cycle pulse per pellet consumed
//   all_cleared   - level: pellet array empty
//   ghost_hit     - level: Pac-Man/ghost overlap
//   state         - IDLE=0 READY=1 PLAY=2 DYING=3 CLEAR=4 OVER=5
//   motion_en     - high only while in PLAY
//   pellet_reload - one-cycle pulse: refill pellets
//   pm_reset      - one-cycle pulse: return Pac-Man to spawn
//   score, lives, level - game registers
module game_sequencer #(
  parameter int SCORE_W     = 16,
  parameter int READY_TICKS = 120,
  parameter int DYING_TICKS = 90,
  parameter int CLEAR_TICKS = 60,
  parameter int START_LIVES = 3,
  parameter int PELLET_PTS  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pellet_eaten,
  input  logic               all_cleared,
  input  logic               ghost_hit,
  output logic [2:0]         state,
  output logic               motion_en,
  output logic               pellet_reload,
  output logic               pm_reset,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [3:0]         level
);

  localparam int TMAX0 = (READY_TICKS > DYING_TICKS) ? READY_TICKS : DYING_TICKS;
  localparam int TMAX  = (TMAX0 > CLEAR_TICKS) ? TMAX0 : CLEAR_TICKS;
  localparam int TW    = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [TW-1:0] READY_LAST = TW'(READY_TICKS - 1);
  localparam logic [TW-1:0] DYING_LAST = TW'(DYING_TICKS - 1);
  localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_TICKS - 1);
  localparam logic [SCORE_W:0] PTS_W   = (SCORE_W+1)'(PELLET_PTS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t            state_q, state_n;
  logic [TW-1:0]     timer_q, timer_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [2:0]        lives_q, lives_n;
  logic [3:0]        level_q, level_n;
  logic              reload_n, pmrst_n;
  logic              start_q, start_edge;
  logic [SCORE_W:0]  score_sum;

  assign start_edge = start & ~start_q;
  // One extra bit catches the carry so the score saturates instead of wrapping.
  assign score_sum  = {1'b0, score_q} + PTS_W;

  always_comb begin
    state_n  = state_q;
    timer_n  = timer_q;
    score_n  = score_q;
    lives_n  = lives_q;
    level_n  = level_q;
    reload_n = 1'b0;
    pmrst_n  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          score_n  = '0;
          lives_n  = 3'(START_LIVES);
          level_n  = 4'd1;
          reload_n = 1'b1;
          pmrst_n  = 1'b1;
          state_n  = READY;
        end
      end
      READY: begin
        if (frame_tick) begin
          if (timer_q == READY_LAST) state_n = PLAY;
          else                       timer_n = timer_q + 1'b1;
        end
      end
      PLAY: begin
        if (pellet_eaten)
          score_n = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (all_cleared) begin
          state_n = CLEAR;
        end else if (ghost_hit) begin
          state_n = DYING;
          if (lives_q != 3'd0) lives_n = lives_q - 3'd1;
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (timer_q == DYING_LAST) begin
            if (lives_q == 3'd0) begin
              state_n = OVER;
            end else begin
              pmrst_n = 1'b1;
              state_n = READY;
            end
          end else begin
            timer_n = timer_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        if (frame_tick) begin
          if (timer_q == CLEAR_LAST) begin
            if (level_q != 4'd15) level_n = level_q + 4'd1;
            reload_n = 1'b1;
            pmrst_n  = 1'b1;
            state_n  = READY;
          end else begin
            timer_n = timer_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Every phase starts its countdown from zero.
    if (state_n != state_q) timer_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      score_q       <= '0;
      lives_q       <= '0;
      level_q       <= '0;
      start_q       <= 1'b0;
      motion_en     <= 1'b0;
      pellet_reload <= 1'b0;
      pm_reset      <= 1'b0;
    end else begin
      state_q       <= state_n;
      timer_q       <= timer_n;
      score_q       <= score_n;
      lives_q       <= lives_n;
      level_q       <= level_n;
      start_q       <= start;
      motion_en     <= (state_n == PLAY);
      pellet_reload <= reload_n;
      pm_reset      <= pmrst_n;
    end
  end

  assign state = state_q;
  assign score = score_q;
  assign lives = lives_q;
  assign level = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  localparam int SW = 16, RT = 4, DT = 3, CT = 2, SL = 2, PP = 10;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic frame_tick = 0, start = 0, pellet_eaten = 0, all_cleared = 0, ghost_hit = 0;
  logic [2:0] state, lives;
  logic [3:0] level;
  logic [SW-1:0] score;
  logic motion_en, pellet_reload, pm_reset;

  game_sequencer #(.SCORE_W(SW), .READY_TICKS(RT), .DYING_TICKS(DT),
                   .CLEAR_TICKS(CT), .START_LIVES(SL), .PELLET_PTS(PP)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .pellet_eaten(pellet_eaten), .all_cleared(all_cleared), .ghost_hit(ghost_hit),
    .state(state), .motion_en(motion_en), .pellet_reload(pellet_reload),
    .pm_reset(pm_reset), .score(score), .lives(lives), .level(level));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_pr = 0, n_pm = 0;

  // Reference model: phase number, tick count within phase, game registers.
  int m_ph, m_ticks, m_score, m_lives, m_level;
  bit m_sq, m_pr, m_pm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_ticks = 0; m_score = 0; m_lives = 0; m_level = 0;
    m_sq = 0; m_pr = 0; m_pm = 0;
  endtask

  task automatic model_step(input bit fr, input bit st, input bit pe, input bit ac, input bit gh);
    int nph;
    bit edge_s;
    edge_s = st && !m_sq;
    m_sq = st;
    m_pr = 0; m_pm = 0;
    nph = m_ph;
    case (m_ph)
      0, 5: if (edge_s) begin
        m_score = 0; m_lives = SL; m_level = 1; m_pr = 1; m_pm = 1; nph = 1;
      end
      1: if (fr) begin
        m_ticks++;
        if (m_ticks == RT) nph = 2;
      end
      2: begin
        if (pe) m_score = (m_score + PP > SMAX) ? SMAX : m_score + PP;
        if (ac) nph = 4;
        else if (gh) begin
          nph = 3;
          if (m_lives > 0) m_lives--;
        end
      end
      3: if (fr) begin
        m_ticks++;
        if (m_ticks == DT) begin
          if (m_lives == 0) nph = 5;
          else begin m_pm = 1; nph = 1; end
        end
      end
      4: if (fr) begin
        m_ticks++;
        if (m_ticks == CT) begin
          m_level = (m_level >= 15) ? 15 : m_level + 1;
          m_pr = 1; m_pm = 1; nph = 1;
        end
      end
      default: nph = 0;
    endcase
    if (nph != m_ph) m_ticks = 0;
    m_ph = nph;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_ph));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
    chk({tag, ".level"}, 32'(level), 32'(m_level));
    chk({tag, ".motion"}, 32'(motion_en), 32'(m_ph == 2));
    chk({tag, ".reload"}, 32'(pellet_reload), 32'(m_pr));
    chk({tag, ".pmrst"}, 32'(pm_reset), 32'(m_pm));
  endtask

  task automatic cyc(input string tag, input bit fr, input bit st, input bit pe,
                     input bit ac, input bit gh);
    @(negedge clk);
    frame_tick = fr; start = st; pellet_eaten = pe; all_cleared = ac; ghost_hit = gh;
    @(posedge clk);
    model_step(fr, st, pe, ac, gh);
    #1;
    check_all(tag);
    if (pellet_reload) n_pr++;
    if (pm_reset) n_pm++;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst = 0;

    // Start held for 5 clocks: one edge only.
    n_pr = 0; n_pm = 0;
    repeat (5) cyc("s2", 0, 1, 0, 0, 0);
    chk("s2.reload_cnt", n_pr, 1);
    chk("s2.pmrst_cnt", n_pm, 1);
    chk("s2.lives", 32'(lives), 2);
    chk("s2.level", 32'(level), 1);
    chk("s2.state", 32'(state), 1);
    cyc("s2b", 0, 0, 0, 0, 0);

    // READY countdown with stray pellets.
    repeat (3) cyc("s3", 1, 0, 1, 0, 0);
    chk("s3.still_ready", 32'(state), 1);
    cyc("s3", 1, 0, 0, 0, 0);
    chk("s3.play", 32'(state), 2);
    chk("s3.motion", 32'(motion_en), 1);
    chk("s3.score0", 32'(score), 0);

    // Scoring and first death.
    repeat (3) cyc("s4", 0, 0, 1, 0, 0);
    chk("s4.score30", 32'(score), 30);
    cyc("s4", 0, 0, 1, 0, 1);
    chk("s4.score40", 32'(score), 40);
    chk("s4.lives1", 32'(lives), 1);
    chk("s4.dying", 32'(state), 3);
    chk("s4.motion0", 32'(motion_en), 0);

    // Respawn, second death, game over, restart.
    repeat (3) cyc("s5", 1, 0, 0, 0, 0);
    chk("s5.pmrst", 32'(pm_reset), 1);
    chk("s5.ready", 32'(state), 1);
    repeat (4) cyc("s5", 1, 0, 0, 0, 0);
    cyc("s5", 0, 0, 0, 0, 1);
    chk("s5.lives0", 32'(lives), 0);
    repeat (3) cyc("s5", 1, 0, 0, 0, 0);
    chk("s5.over", 32'(state), 5);
    cyc("s5", 0, 1, 0, 0, 0);
    chk("s5.rs_score", 32'(score), 0);
    chk("s5.rs_lives", 32'(lives), 2);
    chk("s5.rs_level", 32'(level), 1);
    chk("s5.rs_state", 32'(state), 1);
    cyc("s5", 0, 0, 0, 0, 0);

    // Clear beats ghost; level up; score saturation.
    repeat (4) cyc("s6", 1, 0, 0, 0, 0);
    cyc("s6", 0, 0, 0, 1, 1);
    chk("s6.clear", 32'(state), 4);
    chk("s6.lives", 32'(lives), 2);
    repeat (2) cyc("s6", 1, 0, 0, 0, 0);
    chk("s6.level2", 32'(level), 2);
    chk("s6.reload", 32'(pellet_reload), 1);
    chk("s6.ready", 32'(state), 1);
    repeat (4) cyc("s6", 1, 0, 0, 0, 0);
    for (int i = 0; i < 7000 && m_score < SMAX - 5; i++) cyc("s6p", 0, 0, 1, 0, 0);
    chk("s6.at65530", 32'(score), 65530);
    cyc("s6", 0, 0, 1, 0, 0);
    chk("s6.sat", 32'(score), SMAX);
    cyc("s6", 0, 0, 1, 0, 0);
    chk("s6.sat2", 32'(score), SMAX);

    // Async reset mid-DYING.
    cyc("s7", 0, 0, 0, 0, 1);
    cyc("s7", 1, 0, 0, 0, 0);
    chk("s7.dying", 32'(state), 3);
    @(negedge clk);
    frame_tick = 0; ghost_hit = 0; pellet_eaten = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_all("s7.async");
    @(negedge clk); rst = 0;
    repeat (3) cyc("s7.rel", 0, 0, 0, 0, 0);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      cyc("rnd", $urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0,
          $urandom_range(2, 0) == 0, $urandom_range(39, 0) == 0,
          $urandom_range(15, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
